// File: rtl/xtop.sv
// Sign-magnitude calculator: button-loaded operands, four ALU ops, sticky
// divide-by-zero trap, and a scanned four-digit seven-segment readout.

module xtop_regf (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [7:0] a_w,
   input  logic [7:0] b_w,
   input  logic       ex,
   input  logic [1:0] op_w,
   input  logic       r_we,
   input  logic [7:0] r_w,
   input  logic       trap_w,
   output logic [7:0] a,
   output logic [7:0] b,
   output logic [7:0] r,
   output logic       trap
);
   logic [7:0] regf [16];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regf[i] <= 8'h00;
      end else begin
         if (ld) begin
            regf[0] <= a_w;
            regf[1] <= b_w;
         end
         if (ex)   regf[2] <= {6'b0, op_w};
         if (r_we) regf[3] <= r_w;
         regf[4] <= {7'b0, trap_w};
         for (int i = 5; i < 16; i++) regf[i] <= 8'h00;
      end
   end

   assign a    = regf[0];
   assign b    = regf[1];
   assign r    = regf[3];
   assign trap = regf[4][0];
endmodule

module xtop #(
   parameter int REFRESH_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Btn3,
   input  logic       Btn2,
   input  logic [7:0] Sw,
   output logic [7:0] Led,
   output logic [7:0] Disp,
   output logic [3:0] Disp_sel,
   output logic       trap
);
   logic [7:0] a, b, r;
   logic [7:0] a_w, b_w, r_w;
   logic       ld, ex, div0, r_we, trap_w;
   logic [7:0] div_b, abs_r;
   logic [REFRESH_W-1:0] presc_q, presc_d;
   logic [1:0] idx_q, idx_d;

   function automatic logic [7:0] sm2tc(input logic [3:0] s);
      logic [7:0] mag;
      mag = {5'b0, s[2:0]};
      // negating a zero magnitude yields zero, so -0 stores as 0
      return s[3] ? 8'h00 - mag : mag;
   endfunction

   function automatic logic [7:0] seg(input logic [7:0] v);
      logic [7:0] c;
      case (v)
         8'd0: c = 8'hC0;
         8'd1: c = 8'hF9;
         8'd2: c = 8'hA4;
         8'd3: c = 8'hB0;
         8'd4: c = 8'h99;
         8'd5: c = 8'h92;
         8'd6: c = 8'h82;
         8'd7: c = 8'hF8;
         8'd8: c = 8'h80;
         8'd9: c = 8'h90;
         default: c = 8'hFF;
      endcase
      return c;
   endfunction

   always_comb begin
      ld     = ~trap & Btn3;
      ex     = ~trap & ~Btn3 & Btn2;
      a_w    = sm2tc(Sw[7:4]);
      b_w    = sm2tc(Sw[3:0]);
      div0   = ex & (Sw[1:0] == 2'b10) & (b == 8'h00);
      r_we   = ex & ~div0;
      trap_w = trap | div0;
      div_b  = (b == 8'h00) ? 8'h01 : b;
      r_w    = r;
      case (Sw[1:0])
         2'b00: r_w = a + b;
         2'b01: r_w = a * b;
         2'b10: r_w = $signed(a) / $signed(div_b);
         2'b11: r_w = a - b;
         default: r_w = r;
      endcase
   end

   xtop_regf regf (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .a_w    (a_w),
      .b_w    (b_w),
      .ex     (ex),
      .op_w   (Sw[1:0]),
      .r_we   (r_we),
      .r_w    (r_w),
      .trap_w (trap_w),
      .a      (a),
      .b      (b),
      .r      (r),
      .trap   (trap)
   );

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == '1) idx_d = idx_q + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   assign Led      = r;
   assign abs_r    = r[7] ? 8'h00 - r : r;
   assign Disp_sel = ~(4'b0001 << idx_q);

   always_comb begin
      Disp = 8'hFF;
      case (idx_q)
         2'd0: Disp = seg(abs_r % 8'd10);
         2'd1: Disp = seg((abs_r / 8'd10) % 8'd10);
         2'd2: Disp = seg(abs_r / 8'd100);
         2'd3: Disp = r[7] ? 8'hBF : 8'hFF;
         default: Disp = 8'hFF;
      endcase
   end
endmodule

// File: tb/tb_xtop.sv
// Bench for xtop: directed scenarios then random button/switch traffic
// compared against an integer-arithmetic model of the calculator.

module tb_xtop;
   logic       clk = 1'b0;
   logic       rst;
   logic       Btn3, Btn2;
   logic [7:0] Sw;
   logic [7:0] Led, Disp;
   logic [3:0] Disp_sel;
   logic       trap;

   int checks = 0;
   int errors = 0;

   int ma, mb, mr, mop, cnt;
   bit mt;
   logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   xtop #(.REFRESH_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .Btn3     (Btn3),
      .Btn2     (Btn2),
      .Sw       (Sw),
      .Led      (Led),
      .Disp     (Disp),
      .Disp_sel (Disp_sel),
      .trap     (trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sm(input logic [3:0] s);
      int m;
      m = int'(s[2:0]);
      return s[3] ? -m : m;
   endfunction

   task automatic model_reset();
      ma = 0; mb = 0; mr = 0; mop = 0; mt = 0; cnt = 0;
   endtask

   task automatic check_all();
      int ab, idx;
      logic [7:0] ed;
      logic [3:0] es;
      logic [7:0] v;
      ab  = (mr < 0) ? -mr : mr;
      idx = (cnt / 4) % 4;
      es  = 4'hF;
      es[idx] = 1'b0;
      case (idx)
         0: ed = segtab[ab % 10];
         1: ed = segtab[(ab / 10) % 10];
         2: ed = segtab[ab / 100];
         default: ed = (mr < 0) ? 8'hBF : 8'hFF;
      endcase
      v = mr[7:0];
      chk("led", Led, v);
      chk("trap", trap, mt);
      chk("disp_sel", Disp_sel, es);
      chk("disp", Disp, ed);
      v = ma[7:0];
      chk("regfA", dut.regf.regf[0], v);
      v = mb[7:0];
      chk("regfB", dut.regf.regf[1], v);
      v = mop[7:0];
      chk("regfOp", dut.regf.regf[2], v);
      chk("regfR", dut.regf.regf[3], Led);
      chk("regfT", dut.regf.regf[4], {7'b0, mt});
   endtask

   task automatic step();
      logic r, b3, b2;
      logic [7:0] s;
      r = rst; b3 = Btn3; b2 = Btn2; s = Sw;
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         cnt++;
         if (!mt) begin
            if (b3) begin
               ma = sm(s[7:4]);
               mb = sm(s[3:0]);
            end else if (b2) begin
               mop = int'(s[1:0]);
               case (s[1:0])
                  2'b00: mr = ma + mb;
                  2'b01: mr = ma * mb;
                  2'b10: if (mb == 0) mt = 1; else mr = ma / mb;
                  default: mr = ma - mb;
               endcase
            end
         end
      end
      check_all();
   endtask

   initial begin
      rst = 1'b1; Btn3 = 1'b1; Btn2 = 1'b0; Sw = 8'b1101_0011;
      model_reset();
      #1;
      check_all();
      step();
      step();
      rst = 1'b0;
      step();
      chk("loadA", dut.regf.regf[0], 8'hFB);
      chk("loadB", dut.regf.regf[1], 8'h03);
      Btn3 = 1'b0; Btn2 = 1'b1; Sw = 8'h01;
      step();
      chk("mul_m15", Led, 8'hF1);
      for (int i = 0; i < 16; i++) step();
      Sw = 8'h00; step(); chk("add_m2", Led, 8'hFE);
      Sw = 8'h02; step(); chk("div_m1", Led, 8'hFF);
      Sw = 8'h03; step(); chk("sub_m8", Led, 8'hF8);
      Sw = 8'hFC; step(); chk("add_hi_ignored", Led, 8'hFE);

      Btn2 = 1'b0; Btn3 = 1'b1; Sw = 8'h77; step();
      Btn3 = 1'b0; Btn2 = 1'b1; Sw = 8'h01; step();
      chk("mul_49", Led, 8'h31);
      for (int i = 0; i < 16; i++) step();

      Btn3 = 1'b1; Btn2 = 1'b1; Sw = 8'h8A; step();
      chk("both_R_kept", Led, 8'h31);
      chk("both_A_neg0", dut.regf.regf[0], 8'h00);
      chk("both_B", dut.regf.regf[1], 8'hFE);

      Btn2 = 1'b0; Btn3 = 1'b1; Sw = 8'h50; step();
      Btn3 = 1'b0; Btn2 = 1'b1; Sw = 8'h02; step();
      chk("div0_trap", trap, 1'b1);
      chk("div0_led", Led, 8'h31);
      Btn3 = 1'b1; Sw = 8'h11; step();
      Btn3 = 1'b0; Sw = 8'h00; step();
      chk("trap_hold_led", Led, 8'h31);

      rst = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("async_led", Led, 8'h00);
      chk("async_sel", Disp_sel, 4'hE);
      chk("async_disp", Disp, 8'hC0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom % 50) == 0;
         Btn3 = ($urandom % 4) == 0;
         Btn2 = $urandom % 2;
         Sw   = 8'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
